// File: rtl/reg_file_mp.sv
// Multi-port register file: registered reads, write-to-read bypass, x0 hardwired to zero.
// Define REGFILE_SCOREBOARD_EN to add the per-register busy scoreboard driving rd_busy.
module reg_file_mp #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD*AW-1:0]         rd_addr_out,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_addr
);

    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : gen_chk_regs
        $error("reg_file_mp: NUM_REGS must be a power of 2 and >= 2");
    end
    if ((NUM_WR < 1) || (NUM_WR > 2)) begin : gen_chk_wr
        $error("reg_file_mp: NUM_WR must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0]         mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]         mem_d [NUM_REGS];
    logic [NUM_RD*DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [NUM_RD*AW-1:0]          rd_addr_q;

    // Later ports overwrite earlier ones, so the highest-index write wins; reading
    // mem_d for the read path gives bypass with the same priority for free.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                mem_d[wr_addr[j*AW +: AW]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        mem_d[0] = '0;
    end

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_d[rd_addr[k*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_addr_out = rd_addr_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_RD-1:0]   rd_busy_q, rd_busy_d;

    // Clear on write first, then set on reserve: a same-cycle reserve is the newer producer.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rd_busy_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_d[k] = busy_d[rd_addr[k*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_busy = rd_busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_en, rsv_addr};
    assign rd_busy    = '0;
`endif

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, successor to the 2-read/1-write file in the decode stage.
- Configurable number of read ports and write ports.
- Registered reads with write-to-read bypass; register 0 hardwired to zero.
- Optional per-register busy scoreboard, so the issue stage can detect RAW hazards against in-flight producers.
- Sits between decode (read/reserve side) and writeback (write side).

Parameters:
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
DATA_WIDTH, 32, register width in bits
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NUM_RD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  output  NUM_RD*DATA_WIDTH  registered read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
rd_addr_out  output  NUM_RD*AW  registered copy of rd_addr, aligned with rd_data
rd_busy  output  NUM_RD  registered busy bit of each read address (scoreboard)
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*AW  write addresses
wr_data  input  NUM_WR*DATA_WIDTH  write data
rsv_en  input  1  reserve destination (mark busy) this cycle
rsv_addr  input  AW  register to reserve

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk deassert at the edge):
  - all mem entries = 0
  - rd_data = 0, rd_addr_out = 0, rd_busy = 0, all busy bits = 0
  - Reset asserted mid-write discards that write.
- Write:
  - On a rising edge, each port j with wr_en[j]=1 and wr_addr[j]!=0 writes wr_data[j] to mem[wr_addr[j]].
  - Writes to address 0 are ignored; mem[0] always reads 0.
- Write conflict: two enabled ports with the same nonzero address in one cycle -> the highest-index port wins.
- Read latency: 1 cycle.
  - rd_data[k] at edge N+1 reflects rd_addr[k] sampled at edge N.
  - rd_addr_out[k] is registered from rd_addr[k] on the same edge.
- Bypass: if rd_addr[k]!=0 matches an enabled write port in the same cycle, rd_data[k] captures that port's wr_data (highest-index match), not the stale mem value.
- Address 0 read: rd_data[k] = 0 always, including when a write to 0 is attempted in the same cycle.
- Reads update every cycle unconditionally; there is no read enable.
- Scoreboard (see Optional Feature), one busy bit per register:
  - Set on edge when rsv_en=1 and rsv_addr!=0.
  - Cleared on edge when any enabled write port targets that address.
  - Same-cycle reserve and write of the same address -> the bit ends set (reserve = newer producer wins).
  - busy[0] is constant 0; reserving address 0 is ignored.
  - rd_busy[k] is registered from the next-state busy bit of rd_addr[k]. A same-cycle write therefore reports 0, and a same-cycle reserve reports 1, consistent with bypass.
  - Reserving an already-busy register keeps it busy; there is no counting.
- Parameter checks: NUM_REGS not a power of 2, or NUM_WR>2, is an elaboration error (generate-time $error).

Optional Feature:
Macro: REGFILE_SCOREBOARD_EN
- Defined:
  - Busy-bit array, reserve logic and rd_busy as specified above.
- Undefined:
  - No busy storage is synthesised.
  - rd_busy is tied to 0.
  - rsv_en and rsv_addr are ignored.
  - Read/write/bypass behaviour is unchanged.

Test Plan:
1. Reset then read: rst_n low 2 cycles, release, rd_addr all = 5 -> next cycle rd_data = 0, rd_busy = 0. Assert rst_n low asynchronously mid-cycle -> rd_data drops to 0 before the next edge.
2. Basic write/read: wr port0 x7 = 0xDEADBEEF, one cycle later read port1 x7 -> rd_data[1] = 0xDEADBEEF after 1 cycle, rd_addr_out[1] = 7.
3. Bypass and conflict: same cycle wr0 x3 = 0x11, wr1 x3 = 0x22, rd0 x3 -> rd_data[0] = 0x22; following read of x3 -> 0x22.
4. Zero register: wr0 x0 = 0xFFFFFFFF with rd0 x0 in the same cycle and the next cycle -> rd_data[0] = 0 both times.
5. Scoreboard (macro defined):
   - rsv x9, next cycle read x9 -> rd_busy = 1.
   - wr x9 = 0x5 with rd x9 same cycle -> rd_busy = 0, rd_data = 0x5.
   - rsv x9 and wr x9 same cycle -> busy remains 1.
   - rsv x0 -> rd_busy for x0 stays 0.
6. Macro undefined: repeat scenario 5 stimulus -> rd_busy = 0 throughout, data results identical.
